// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Replays a marked FIFO region cfg_passes times onto a ready/valid
//            stream, absorbing pop-to-data latency in a small skid buffer.
//            Optional drop statistics: FIFO_STREAM_READER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DWIDTH     = 16,
    parameter int LEN_W      = 6,
    parameter int PASS_W     = 8,
    parameter int FIFO_LAT   = 3,
    parameter int SKID_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [PASS_W-1:0] cfg_passes,
    output logic              busy,
    output logic              done,
    output logic              fifo_pop,
    output logic              fifo_mark,
    output logic              fifo_read_rst,
    input  logic [DWIDTH-1:0] fifo_front,
    input  logic              fifo_vld,
    input  logic              fifo_empty,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [PASS_W-1:0] m_pass,
    output logic [15:0]       stat_drop_cnt
);

    localparam int c_PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int c_OCC_W = $clog2(SKID_DEPTH + FIFO_LAT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MARK0  = 3'd1,
        MARK1  = 3'd2,
        READ   = 3'd3,
        REWIND = 3'd4,
        SETTLE = 3'd5,
        DRAIN  = 3'd6
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_req_cnt;
    logic [LEN_W-1:0]    r_rx_cnt;
    logic [PASS_W-1:0]   r_passes;
    logic [PASS_W-1:0]   r_pass;
    logic                r_done;
    logic [FIFO_LAT-1:0] r_pipe;

    logic [DWIDTH-1:0]   r_sk_data [SKID_DEPTH];
    logic [PASS_W-1:0]   r_sk_pass [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] r_sk_last;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_OCC_W-1:0]  r_sk_cnt;

    logic [c_OCC_W-1:0]  w_inflight;
    logic                w_pop;
    logic                w_accept;
    logic                w_drop;
    logic                w_xfer;
    logic                w_last_word;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(SKID_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < FIFO_LAT; i++) begin
            w_inflight = w_inflight + c_OCC_W'(r_pipe[i]);
        end
    end

    // The oldest slot of r_pipe lines up with the cycle its data comes back.
    assign w_accept    = r_pipe[FIFO_LAT-1] & fifo_vld;
    assign w_drop      = r_pipe[FIFO_LAT-1] & ~fifo_vld;
    assign w_xfer      = m_valid & m_ready;
    assign w_last_word = (r_rx_cnt == r_len - LEN_W'(1));
    assign w_pop       = (r_state == READ) && !fifo_empty && (r_req_cnt < r_len)
                         && ((r_sk_cnt + w_inflight) < c_OCC_W'(SKID_DEPTH));

    generate
        if (FIFO_LAT > 1) begin : g_pipe_shift
            always_ff @(posedge clk) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= {r_pipe[FIFO_LAT-2:0], w_pop};
            end
        end else begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= w_pop;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_passes  <= '0;
            r_pass    <= '0;
            r_req_cnt <= '0;
            r_rx_cnt  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            // A dropped pop is handed back so the same word is asked for again.
            r_req_cnt <= r_req_cnt + LEN_W'(w_pop) - LEN_W'(w_drop);
            if (w_accept) r_rx_cnt <= r_rx_cnt + LEN_W'(1);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len     <= cfg_len;
                        r_passes  <= cfg_passes;
                        r_pass    <= '0;
                        r_req_cnt <= '0;
                        r_rx_cnt  <= '0;
                        if (cfg_len == '0 || cfg_passes == '0) r_done  <= 1'b1;
                        else                                   r_state <= MARK0;
                    end
                end
                MARK0:  r_state <= MARK1;
                MARK1:  r_state <= READ;
                READ: begin
                    if (r_req_cnt == r_len && w_inflight == '0) begin
                        if (r_pass < r_passes - PASS_W'(1)) r_state <= REWIND;
                        else                                r_state <= DRAIN;
                    end
                end
                REWIND: begin
                    r_pass    <= r_pass + PASS_W'(1);
                    r_req_cnt <= '0;
                    r_rx_cnt  <= '0;
                    r_state   <= SETTLE;
                end
                SETTLE: r_state <= READ;
                DRAIN: begin
                    if (r_sk_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_sk_cnt  <= '0;
            r_sk_last <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_sk_data[i] <= '0;
                r_sk_pass[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_sk_data[r_wr_ptr] <= fifo_front;
                r_sk_last[r_wr_ptr] <= w_last_word;
                r_sk_pass[r_wr_ptr] <= r_pass;
                r_wr_ptr            <= f_ptr_inc(r_wr_ptr);
            end
            if (w_xfer) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            r_sk_cnt <= r_sk_cnt + c_OCC_W'(w_accept) - c_OCC_W'(w_xfer);
        end
    end

    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign fifo_pop      = w_pop;
    assign fifo_mark     = (r_state == MARK1);
    assign fifo_read_rst = (r_state == REWIND);
    assign m_valid       = (r_sk_cnt != '0);
    assign m_data        = r_sk_data[r_rd_ptr];
    assign m_last        = m_valid & r_sk_last[r_rd_ptr];
    assign m_pass        = r_sk_pass[r_rd_ptr];

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)                                r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign stat_drop_cnt = r_drop_cnt;
`else
    assign stat_drop_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Brief    : Directed self-checking bench with a latency FIFO model that
//            supports mark / rewind and injected dropped pops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  cfg_len;
    logic [7:0]  cfg_passes;
    logic        busy, done, fifo_pop, fifo_mark, fifo_read_rst;
    logic [15:0] fifo_front;
    logic        fifo_vld, fifo_empty;
    logic [15:0] m_data;
    logic        m_valid, m_ready, m_last;
    logic [7:0]  m_pass;
    logic [15:0] stat_drop_cnt;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DWIDTH(16), .LEN_W(6), .PASS_W(8), .FIFO_LAT(3), .SKID_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .cfg_passes(cfg_passes), .busy(busy), .done(done), .fifo_pop(fifo_pop),
        .fifo_mark(fifo_mark), .fifo_read_rst(fifo_read_rst),
        .fifo_front(fifo_front), .fifo_vld(fifo_vld), .fifo_empty(fifo_empty),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .m_pass(m_pass), .stat_drop_cnt(stat_drop_cnt)
    );

    // FIFO model: 3-cycle pop-to-data latency, mark/rewind pointer, drop mask.
    logic [15:0] f_mem [64];
    int          f_fill;
    logic        f_clr;
    logic [31:0] f_drop_mask;
    int          f_rd, f_mark, f_popn;
    logic [2:0]  f_pp, f_vp;
    logic [15:0] f_dp [3];

    assign fifo_empty = (f_rd >= f_fill);
    assign fifo_vld   = f_vp[2];
    assign fifo_front = f_dp[2];

    always @(posedge clk) begin : p_fifo
        logic acc;
        if (f_clr) begin
            f_rd <= 0; f_mark <= 0; f_popn <= 0;
            f_pp <= '0; f_vp <= '0;
            f_dp[0] <= '0; f_dp[1] <= '0; f_dp[2] <= '0;
        end else begin
            acc = fifo_pop && !fifo_empty && !(f_popn < 32 && f_drop_mask[f_popn]);
            f_pp    <= {f_pp[1:0], fifo_pop};
            f_vp    <= {f_vp[1:0], acc};
            f_dp[0] <= acc ? f_mem[f_rd] : 16'h0;
            f_dp[1] <= f_dp[0];
            f_dp[2] <= f_dp[1];
            if (fifo_pop && !fifo_empty) f_popn <= f_popn + 1;
            if (acc)                     f_rd   <= f_rd + 1;
            if (fifo_mark)               f_mark <= f_rd;
            if (fifo_read_rst)           f_rd   <= f_mark;
        end
    end

    // Stream monitor
    int          rcv = 0, xfer = 0, occ_max = 0, stall_err = 0;
    int          mark_n = 0, rrst_n = 0, done_n = 0, pop_n = 0;
    logic [15:0] qd [$];
    logic        ql [$];
    logic [7:0]  qp [$];
    logic        st_prev = 1'b0;
    logic [15:0] st_d;
    logic        st_l;
    logic [7:0]  st_p;

    always @(negedge clk) begin : p_mon
        int occ;
        if (rst_n === 1'b1) begin
            occ = rcv - xfer + int'(f_pp[0]) + int'(f_pp[1]) + int'(f_pp[2]);
            if (occ > occ_max) occ_max <= occ;
            rcv <= rcv + int'(fifo_vld);
            if (m_valid && m_ready) begin
                qd.push_back(m_data);
                ql.push_back(m_last);
                qp.push_back(m_pass);
                xfer <= xfer + 1;
            end
            if (st_prev && (!m_valid || m_data !== st_d || m_last !== st_l || m_pass !== st_p))
                stall_err <= stall_err + 1;
            st_prev <= m_valid && !m_ready;
            st_d    <= m_data;
            st_l    <= m_last;
            st_p    <= m_pass;
            mark_n  <= mark_n + int'(fifo_mark);
            rrst_n  <= rrst_n + int'(fifo_read_rst);
            done_n  <= done_n + int'(done);
            pop_n   <= pop_n + int'(fifo_pop);
        end else begin
            st_prev <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_fill(input int n);
        f_fill = n;
        f_clr  = 1'b1;
        tick(1);
        f_clr  = 1'b0;
    endtask

    task automatic start_job(input logic [5:0] len, input logic [7:0] passes);
        cfg_len    = len;
        cfg_passes = passes;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int got;
        got = 0;
        for (int k = 0; k < budget && got == 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1;
        end
        chk(tag, got, 1);
        tick(2);
    endtask

    task automatic chk_word(input int idx, input logic [15:0] d, input logic l,
                            input logic [7:0] p, input string tag);
        if (idx < qd.size()) begin
            chk({tag, "_data"}, qd[idx], d);
            chk({tag, "_last"}, ql[idx], l);
            chk({tag, "_pass"}, qp[idx], p);
        end else begin
            chk({tag, "_missing"}, 0, 1);
        end
    endtask

    int          b, bm, br, bd, bp;
    logic [15:0] t2v [3];

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_passes = '0; m_ready = 1'b1;
        f_clr = 1'b1; f_fill = 0; f_drop_mask = '0;
        t2v[0] = 16'd10; t2v[1] = 16'd20; t2v[2] = 16'd30;
        tick(3);

        // Reset state
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_pop", fifo_pop, 0);    chk("rst_mark", fifo_mark, 0);
        chk("rst_rrst", fifo_read_rst, 0);
        chk("rst_valid", m_valid, 0);   chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);     chk("rst_pass", m_pass, 0);
        chk("rst_stat", stat_drop_cnt, 0);
        rst_n = 1'b1; f_clr = 1'b0;
        tick(1);

        // Single pass 1..8, with an ignored start while busy
        for (int i = 0; i < 8; i++) f_mem[i] = 16'(i + 1);
        set_fill(8);
        b = qd.size(); bm = mark_n; br = rrst_n; bd = done_n;
        start_job(6'd8, 8'd1);
        tick(3);
        chk("t1_busy", busy, 1);
        start_job(6'd2, 8'd5);
        wait_done(300, "t1_done_seen");
        chk("t1_count", qd.size() - b, 8);
        for (int i = 0; i < 8; i++) chk_word(b + i, 16'(i + 1), i == 7, 8'd0, "t1");
        chk("t1_mark", mark_n - bm, 1);
        chk("t1_rrst", rrst_n - br, 0);
        chk("t1_done_n", done_n - bd, 1);
        chk("t1_idle", busy, 0);

        // Three passes over 10,20,30
        for (int i = 0; i < 3; i++) f_mem[i] = t2v[i];
        set_fill(3);
        b = qd.size(); bm = mark_n; br = rrst_n; bd = done_n;
        start_job(6'd3, 8'd3);
        wait_done(400, "t2_done_seen");
        chk("t2_count", qd.size() - b, 9);
        for (int i = 0; i < 9; i++) chk_word(b + i, t2v[i % 3], (i % 3) == 2, 8'(i / 3), "t2");
        chk("t2_rrst", rrst_n - br, 2);
        chk("t2_mark", mark_n - bm, 1);
        chk("t2_done_n", done_n - bd, 1);

        // Back-pressure: m_ready high one cycle in three
        for (int i = 0; i < 16; i++) f_mem[i] = 16'(i * 7 + 3);
        set_fill(16);
        b = qd.size(); bd = done_n;
        m_ready = 1'b0;
        start_job(6'd16, 8'd1);
        for (int k = 0; k < 800 && done_n == bd; k++) begin
            @(posedge clk); #1;
            m_ready = (k % 3 == 0);
        end
        m_ready = 1'b1;
        chk("t3_done_n", done_n - bd, 1);
        tick(2);
        chk("t3_count", qd.size() - b, 16);
        for (int i = 0; i < 16; i++) chk_word(b + i, 16'(i * 7 + 3), i == 15, 8'd0, "t3");
        chk("t3_stall_stable", stall_err, 0);
        chk("t3_occ_le4", occ_max <= 4, 1);

        // Dropped pops: pops #2 and #5 return no data
        for (int i = 0; i < 10; i++) f_mem[i] = 16'(100 + i);
        f_drop_mask = 32'h0000_0024;
        set_fill(10);
        b = qd.size(); bp = pop_n;
        start_job(6'd10, 8'd1);
        wait_done(400, "t4_done_seen");
        chk("t4_count", qd.size() - b, 10);
        for (int i = 0; i < 10; i++) chk_word(b + i, 16'(100 + i), i == 9, 8'd0, "t4");
        chk("t4_pops", pop_n - bp, 12);
`ifdef FIFO_STREAM_READER_STATS_EN
        chk("t4_stat", stat_drop_cnt, 2);
`else
        chk("t4_stat", stat_drop_cnt, 0);
`endif
        f_drop_mask = '0;

        // Degenerate jobs: zero length / zero passes
        set_fill(8);
        bp = pop_n; bm = mark_n;
        start_job(6'd0, 8'd2);
        chk("t5_len0_done", done, 1);
        chk("t5_len0_busy", busy, 0);
        chk("t5_len0_pop", fifo_pop, 0);
        tick(1);
        chk("t5_done_clear", done, 0);
        start_job(6'd4, 8'd0);
        chk("t5_pass0_done", done, 1);
        tick(3);
        chk("t5_no_pop", pop_n - bp, 0);
        chk("t5_no_mark", mark_n - bm, 0);
        chk("t5_idle", busy, 0);

        // Reset during pass 1 of 3
        for (int i = 0; i < 3; i++) f_mem[i] = t2v[i];
        set_fill(3);
        br = rrst_n;
        start_job(6'd3, 8'd3);
        for (int k = 0; k < 300 && rrst_n == br; k++) tick(1);
        chk("t6_reached_pass1", rrst_n - br, 1);
        tick(3);
        bd = done_n;
        rst_n = 1'b0;
        tick(1);
        chk("t6_busy", busy, 0);        chk("t6_done", done, 0);
        chk("t6_pop", fifo_pop, 0);     chk("t6_mark", fifo_mark, 0);
        chk("t6_rrst", fifo_read_rst, 0);
        chk("t6_valid", m_valid, 0);    chk("t6_last", m_last, 0);
        chk("t6_data", m_data, 0);      chk("t6_pass", m_pass, 0);
        chk("t6_stat", stat_drop_cnt, 0);
        tick(1);
        rst_n = 1'b1;
        b = qd.size();
        tick(8);
        chk("t6_no_done", done_n - bd, 0);
        chk("t6_no_stray_words", qd.size() - b, 0);
        set_fill(3);
        b = qd.size(); bd = done_n;
        start_job(6'd3, 8'd1);
        wait_done(300, "t6_rerun_done_seen");
        chk("t6_rerun_count", qd.size() - b, 3);
        for (int i = 0; i < 3; i++) chk_word(b + i, t2v[i], i == 2, 8'd0, "t6");
        chk("t6_rerun_done_n", done_n - bd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
